number_select: RTL
==================

# number_select

Parametrised, fully synchronous value selector for the front-panel UI, superseding the earlier button-clocked 4-bit selector. Two raw push buttons are synchronised, debounced and edge-detected on the system clock. One button steps a working value up or down by a configurable step, with either saturating or wrapping bounds. The other commits the working value to a registered output consumed by downstream control logic.

## Interface
- `WIDTH`, 4, bit width of working and committed values
- `STEP`, 2, increment/decrement amount; 1 ≤ STEP ≤ MAX_VAL−MIN_VAL
- `MIN_VAL`, 0, lower bound; reset value of both working and committed values
- `MAX_VAL`, 14, upper bound; MIN_VAL < MAX_VAL ≤ 2^WIDTH−1
- `WRAP`, 0, 0 = saturate at bounds, 1 = wrap to opposite bound
- `DEBOUNCE`, 16, consecutive stable cycles required before a debounced level changes; ≥ 1
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sel_en`  in  1  selection mode enable; level, from a slide switch
- `dir_up`  in  1  1 = step up, 0 = step down; level, from a slide switch
- `btn`  in  2  raw asynchronous buttons; `btn[0]` = step, `btn[1]` = commit
- `working`  out  WIDTH  value currently being edited
- `value`  out  WIDTH  last committed value
- `commit_pulse`  out  1  high for exactly one cycle per accepted commit
- `dirty`  out  1  registered; high when `working` ≠ `value`

## Operation
- Per-button conditioning:
  - 2-flop synchroniser (`s1` → `s2`), then a debouncer holding level `db` (reset 0) and a counter (reset 0).
  - When `s2 == db`, the counter clears.
  - When `s2 != db`, the counter increments. When it reaches DEBOUNCE−1 while `s2` still differs, `db` takes `s2` and the counter clears.
  - A press event is a 0→1 transition of `db`. A release generates no event.
- `sel_en`, `dir_up` are treated as quasi-static. They are sampled directly on the edge where a press event is acted upon.
- Step event (`btn[0]` press) with `sel_en` = 1:
  - Up: if `working` > MAX_VAL−STEP, then `working` ← (WRAP ? MIN_VAL : MAX_VAL); else `working` ← `working`+STEP.
  - Down: if `working` < MIN_VAL+STEP, then `working` ← (WRAP ? MAX_VAL : MIN_VAL); else `working` ← `working`−STEP.
  - All comparisons are unsigned at WIDTH+1 bits, so no intermediate overflow occurs.
- Commit event (`btn[1]` press) with `sel_en` = 1: `value` ← `working`; `commit_pulse` = 1 for one cycle.
- Any event with `sel_en` = 0 is discarded entirely. It is not queued, and it does not produce `commit_pulse`.
- Simultaneous step and commit on the same edge: commit captures the pre-step `working`. `working` still steps, so `dirty` = 1 afterwards unless the step saturated at a bound.
- Holding a button produces one event only. A new event requires release, debounced low, then a new press.
- Out-of-range `working` is unreachable. Both registers are bounded by construction.

## Timing
- Reset: `working` = `value` = MIN_VAL, `commit_pulse` = 0, `dirty` = 0; all synchronisers, `db` and counters = 0.
  - Reset asserted mid-debounce discards the pending press.
  - After `rst_n` deasserts, a button already held is seen as a fresh press once debounced.
- Press latency:
  - Raw level high before edge k gives `s2` high after edge k+1.
  - `db` rises at edge k+1+DEBOUNCE.
  - `working`/`value`/`commit_pulse` update at that same edge.
- Glitches shorter than DEBOUNCE cycles at `s2` produce no event. A bounce resets the counter.
- `dirty` updates one edge after `working`/`value` change (registered compare).
- `commit_pulse` deasserts on the following edge unconditionally.

## Test plan
- Reset, defaults: hold `rst_n` = 0 → `working` = `value` = 0, `dirty` = 0, `commit_pulse` = 0; release reset, no buttons pressed → all outputs unchanged for 100 cycles.
- Step up, then commit (`sel_en` = 1, `dir_up` = 1): 3 clean `btn[0]` presses → `working` = 6, `dirty` = 1. `btn[1]` press → `value` = 6, one-cycle `commit_pulse`, then `dirty` = 0. Each event lands at exactly 2+DEBOUNCE edges after the raw rise.
- Saturation (WRAP = 0): 8 up presses from 0 → `working` = 14 after the 7th and stays 14. Down presses from 0 → `working` stays 0.
- Wrap (WRAP = 1): from 14, up press → 0. From 0, down press → 14.
- Bounce and disable:
  - `btn[0]` toggling every 3 cycles for 40 cycles, then stable high → exactly one step.
  - Presses on both buttons with `sel_en` = 0 → no change, no `commit_pulse`.
  - Hold a button for 500 cycles → one event only.
- Simultaneous and reset cases:
  - Step and commit debounced on the same edge with `working` = 4, up → `value` = 4, `working` = 6.
  - `rst_n` pulsed low mid-debounce → no event; all outputs = 0 asynchronously.

Source files
------------

// File: rtl/number_select.sv
// Two-button value selector: synchronised, debounced buttons step a working
// value within [MIN_VAL, MAX_VAL] and commit it to a registered output.
module number_select #(
  parameter int WIDTH    = 4,
  parameter int STEP     = 2,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 14,
  parameter int WRAP     = 0,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel_en,
  input  logic             dir_up,
  input  logic [1:0]       btn,
  output logic [WIDTH-1:0] working,
  output logic [WIDTH-1:0] value,
  output logic             commit_pulse,
  output logic             dirty
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0]    CNT_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [WIDTH:0]   UP_LIMIT   = (WIDTH+1)'(MAX_VAL - STEP);
  localparam logic [WIDTH:0]   DOWN_LIMIT = (WIDTH+1)'(MIN_VAL + STEP);
  localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  logic [1:0]          s1_q, s2_q;
  logic [1:0]          db_q, db_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [1:0]          press;
  logic                step_ev, commit_ev;
  logic [WIDTH:0]      w_ext;
  logic [WIDTH-1:0]    stepped;
  logic [WIDTH-1:0]    working_q, working_d;
  logic [WIDTH-1:0]    value_q, value_d;
  logic                commit_pulse_q, commit_pulse_d;
  logic                dirty_q, dirty_d;

  // Debounce: db follows s2 only after it has differed for DEBOUNCE cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    press = db_d & ~db_q;
  end

  always_comb begin
    step_ev   = press[0] & sel_en;
    commit_ev = press[1] & sel_en;
    w_ext     = {1'b0, working_q};
    if (dir_up) begin
      stepped = (w_ext > UP_LIMIT) ? ((WRAP != 0) ? MIN_W : MAX_W)
                                   : working_q + STEP_W;
    end else begin
      stepped = (w_ext < DOWN_LIMIT) ? ((WRAP != 0) ? MAX_W : MIN_W)
                                     : working_q - STEP_W;
    end
    working_d      = step_ev ? stepped : working_q;
    value_d        = commit_ev ? working_q : value_q;
    commit_pulse_d = commit_ev;
    dirty_d        = (working_q != value_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= '0;
      s2_q           <= '0;
      db_q           <= '0;
      cnt_q          <= '0;
      working_q      <= MIN_W;
      value_q        <= MIN_W;
      commit_pulse_q <= 1'b0;
      dirty_q        <= 1'b0;
    end else begin
      s1_q           <= btn;
      s2_q           <= s1_q;
      db_q           <= db_d;
      cnt_q          <= cnt_d;
      working_q      <= working_d;
      value_q        <= value_d;
      commit_pulse_q <= commit_pulse_d;
      dirty_q        <= dirty_d;
    end
  end

  assign working      = working_q;
  assign value        = value_q;
  assign commit_pulse = commit_pulse_q;
  assign dirty        = dirty_q;

endmodule
